// File: rtl/line_window_gen.sv
// line_window_gen: streaming 3x3 gray neighbourhood generator.
// RGB pixels arrive in raster order; each accepted pixel is converted to 8-bit
// gray, pushed through two line buffers and a three-column shift window, and
// one zero-padded 3x3 window per image pixel is emitted in raster order. The
// window centre trails the input by one row plus one column. Once the last
// pixel of the frame is in, WIDTH+1 virtual zero pixels drain the remaining
// windows.
module line_window_gen #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int COORD_BITS = 11
) (
  input  logic                  CAMERA_CLK,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_R,
  input  logic [7:0]            in_G,
  input  logic [7:0]            in_B,
  output logic                  win_valid,
  output logic [7:0]            ul,
  output logic [7:0]            uc,
  output logic [7:0]            ur,
  output logic [7:0]            ml,
  output logic [7:0]            mc,
  output logic [7:0]            mr,
  output logic [7:0]            dl,
  output logic [7:0]            dc,
  output logic [7:0]            dr,
  output logic [COORD_BITS-1:0] win_row,
  output logic [COORD_BITS-1:0] win_col,
  output logic                  frame_done
);

  localparam int ADDR_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COORD_BITS-1:0] LAST_COL   = COORD_BITS'(WIDTH - 1);
  localparam logic [COORD_BITS-1:0] LAST_ROW   = COORD_BITS'(HEIGHT - 1);
  localparam logic [COORD_BITS-1:0] COORD_ZERO = {COORD_BITS{1'b0}};
  localparam logic [COORD_BITS-1:0] COORD_ONE  = COORD_BITS'(1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } stateT;

  // Rounded luma approximation; the 10-bit sum peaks at 1022, so the result
  // never exceeds 255 and needs no clamp.
  function automatic logic [7:0] grayOf(input logic [7:0] r,
                                        input logic [7:0] g,
                                        input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b} + 10'd2;
    return sum[9:2];
  endfunction

  stateT state;

  // Line buffers indexed by column: lineBufNew holds the previous row,
  // lineBufOld the row before that. Contents are never cleared; out-of-image
  // taps are masked by the centre coordinates instead.
  logic [7:0] lineBufOld [WIDTH];
  logic [7:0] lineBufNew [WIDTH];

  // Shift window columns packed as {top, mid, bot}: colA = left, colB = centre.
  logic [23:0] colA;
  logic [23:0] colB;

  // Coordinates of the next pixel to enter and of the next window centre.
  logic [COORD_BITS-1:0] inRow;
  logic [COORD_BITS-1:0] inCol;
  logic [COORD_BITS-1:0] outRow;
  logic [COORD_BITS-1:0] outCol;

  logic                 accept;
  logic                 advance;
  logic                 emit;
  logic [7:0]           pixGray;
  logic [7:0]           newTop;
  logic [7:0]           newMid;
  logic [7:0]           newBot;
  logic [ADDR_BITS-1:0] bufAddr;
  logic                 rowFirst;
  logic                 rowLast;
  logic                 colFirst;
  logic                 colLast;
  logic                 inColLast;
  logic                 lastInPix;
  logic                 lastWin;
  logic                 fillDone;

  // Decide whether the pipeline advances this cycle and what the new column is.
  always_comb begin
    pixGray = grayOf(in_R, in_G, in_B);
    accept  = in_valid & in_ready;
    advance = 1'b0;
    emit    = 1'b0;
    newBot  = 8'd0;
    case (state)
      FILL: begin
        advance = accept;
        emit    = 1'b0;
        newBot  = pixGray;
      end
      STREAM: begin
        advance = accept;
        emit    = accept;
        newBot  = pixGray;
      end
      FLUSH: begin
        advance = 1'b1;
        emit    = 1'b1;
        newBot  = 8'd0;
      end
      DONE: begin
        // Counters are already cleared, so a pixel here is (0,0) of the next frame.
        advance = accept;
        emit    = 1'b0;
        newBot  = pixGray;
      end
      default: begin
        advance = 1'b0;
        emit    = 1'b0;
        newBot  = 8'd0;
      end
    endcase
    bufAddr   = inCol[ADDR_BITS-1:0];
    newTop    = lineBufOld[bufAddr];
    newMid    = lineBufNew[bufAddr];
    rowFirst  = (outRow == COORD_ZERO);
    rowLast   = (outRow == LAST_ROW);
    colFirst  = (outCol == COORD_ZERO);
    colLast   = (outCol == LAST_COL);
    inColLast = (inCol == LAST_COL);
    lastInPix = (inRow == LAST_ROW) && inColLast;
    lastWin   = rowLast && colLast;
    fillDone  = (inRow == COORD_ONE) && (inCol == COORD_ZERO);
  end

  // Line buffer update: the previous row moves up, the new pixel becomes the previous row.
  always_ff @(posedge CAMERA_CLK) begin
    if (advance) begin
      lineBufOld[bufAddr] <= newMid;
      lineBufNew[bufAddr] <= newBot;
    end
  end

  // Control FSM, coordinate counters, shift window and registered window outputs.
  always_ff @(posedge CAMERA_CLK) begin
    if (rst) begin
      state      <= FILL;
      in_ready   <= 1'b1;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      ul <= 8'd0; uc <= 8'd0; ur <= 8'd0;
      ml <= 8'd0; mc <= 8'd0; mr <= 8'd0;
      dl <= 8'd0; dc <= 8'd0; dr <= 8'd0;
      win_row    <= COORD_ZERO;
      win_col    <= COORD_ZERO;
      inRow      <= COORD_ZERO;
      inCol      <= COORD_ZERO;
      outRow     <= COORD_ZERO;
      outCol     <= COORD_ZERO;
      colA       <= 24'd0;
      colB       <= 24'd0;
    end else begin
      win_valid  <= emit;
      frame_done <= (state == DONE);

      if (advance) begin
        colA <= colB;
        colB <= {newTop, newMid, newBot};
        if (inColLast) begin
          inCol <= COORD_ZERO;
          inRow <= inRow + COORD_ONE;
        end else begin
          inCol <= inCol + COORD_ONE;
        end
      end

      if (emit) begin
        ul <= (rowFirst || colFirst) ? 8'd0 : colA[23:16];
        uc <= rowFirst               ? 8'd0 : colB[23:16];
        ur <= (rowFirst || colLast)  ? 8'd0 : newTop;
        ml <= colFirst               ? 8'd0 : colA[15:8];
        mc <= colB[15:8];
        mr <= colLast                ? 8'd0 : newMid;
        dl <= (rowLast || colFirst)  ? 8'd0 : colA[7:0];
        dc <= rowLast                ? 8'd0 : colB[7:0];
        dr <= (rowLast || colLast)   ? 8'd0 : newBot;
        win_row <= outRow;
        win_col <= outCol;
        if (colLast) begin
          outCol <= COORD_ZERO;
          outRow <= outRow + COORD_ONE;
        end else begin
          outCol <= outCol + COORD_ONE;
        end
      end

      case (state)
        FILL: begin
          if (advance && fillDone) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (advance && lastInPix) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end
        end
        FLUSH: begin
          if (lastWin) begin
            // Clearing here overrides the increments above for this cycle.
            state    <= DONE;
            in_ready <= 1'b1;
            inRow    <= COORD_ZERO;
            inCol    <= COORD_ZERO;
            outRow   <= COORD_ZERO;
            outCol   <= COORD_ZERO;
          end
        end
        DONE: begin
          state <= FILL;
        end
        default: begin
          state    <= FILL;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
